// File: rtl/demux4_pkg.sv
// Shared lane typedefs and constants for the 1:4 dispatcher.
package demux4_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] lane_idx_t;

    localparam lane_idx_t LANE_A = 2'd0;
    localparam lane_idx_t LANE_B = 2'd1;
    localparam lane_idx_t LANE_C = 2'd2;
    localparam lane_idx_t LANE_D = 2'd3;

    // Round-robin successor; 3 wraps back to 0.
    function automatic lane_idx_t next_lane(input lane_idx_t cur);
        return lane_idx_t'(cur + lane_idx_t'(1));
    endfunction

endpackage

// File: rtl/demux4_dispatch_lane_fifo.sv
// Per-lane first-word-fall-through FIFO; DEPTH must be a power of two >= 2.
module lane_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Guard locally so the FIFO never overruns or underruns on its own.
    assign push_ok = push && !full;
    assign pop_ok  = pop && not_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign not_empty = (count_q != CNT_W'(0));
    assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/demux4_dispatch.sv
// Flow-controlled 1:4 dispatcher: addressed or round-robin lane choice,
// one FWFT FIFO per lane, and an accepted-word counter.
module demux4_dispatch
    import demux4_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [1:0]             in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   rr_mode,
    output logic [4*WIDTH-1:0]     out_data,
    output logic [3:0]             out_valid,
    input  logic [3:0]             out_ready,
    output logic [3:0]             lane_full,
    output logic [15:0]            acc_cnt
);

    localparam int unsigned CNT_W = 16;

    lane_idx_t        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    lane_idx_t        target_lane;
    logic             accept;
    logic [LANES-1:0] push_vec;
    logic [LANES-1:0] pop_vec;

    // Readiness looks only at registered lane state, so a full lane
    // stays blocked even if it is being popped this cycle.
    always_comb begin
        target_lane = rr_mode ? rr_ptr_q : lane_idx_t'(in_sel);
        in_ready    = !lane_full[target_lane] && !rst;
        accept      = in_valid && in_ready;
    end

    always_comb begin
        push_vec = '0;
        pop_vec  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            push_vec[i] = accept && (target_lane == lane_idx_t'(i));
            pop_vec[i]  = out_valid[i] && out_ready[i] && !rst;
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        acc_cnt_d = acc_cnt_q;
        if (accept) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
            if (rr_mode) begin
                rr_ptr_d = next_lane(rr_ptr_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= LANE_A;
            acc_cnt_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign acc_cnt = acc_cnt_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_vec[g]),
            .push_data (in_data),
            .pop       (pop_vec[g]),
            .head_data (out_data[g*WIDTH +: WIDTH]),
            .not_empty (out_valid[g]),
            .full      (lane_full[g])
        );
    end

endmodule

// File: tb/tb_demux4_dispatch.sv
// Directed self-checking bench for demux4_dispatch (WIDTH=8, DEPTH=2).
module tb_demux4_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic        rr_mode;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [3:0]  lane_full;
    logic [15:0] acc_cnt;

    int total = 0;
    int bad   = 0;

    demux4_dispatch #(.WIDTH(8), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rr_mode   (rr_mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lane_full (lane_full),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lane_word(input int i);
        return out_data[i*8 +: 8];
    endfunction

    task automatic send(input logic [7:0] d, input logic [1:0] s);
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
    endtask

    initial begin
        logic [7:0] rr_words [7];
        int         rr_lanes [7];

        rr_words = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        rr_lanes = '{0, 1, 2, 3, 0, 1, 2};

        // Reset held for three edges with a valid word waiting
        rst = 1'b1; in_data = 8'h99; in_sel = 2'd0; in_valid = 1'b1;
        rr_mode = 1'b0; out_ready = 4'b0000;
        tick(); tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_acc_cnt", 32'(acc_cnt), 32'd0);
        chk("rst_lane_full", 32'(lane_full), 32'h0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);

        // Addressed routing a,b,c,d with all consumers ready
        out_ready = 4'b1111;
        send(8'h11, 2'd0); tick();
        chk("addr_a_valid", 32'(out_valid), 32'b0001);
        chk("addr_a_data", 32'(lane_word(0)), 32'h11);
        send(8'h22, 2'd1); tick();
        chk("addr_b_valid", 32'(out_valid), 32'b0010);
        chk("addr_b_data", 32'(lane_word(1)), 32'h22);
        send(8'h33, 2'd2); tick();
        chk("addr_c_valid", 32'(out_valid), 32'b0100);
        chk("addr_c_data", 32'(lane_word(2)), 32'h33);
        send(8'h44, 2'd3); tick();
        chk("addr_d_valid", 32'(out_valid), 32'b1000);
        chk("addr_d_data", 32'(lane_word(3)), 32'h44);
        chk("addr_acc_cnt", 32'(acc_cnt), 32'd4);
        in_valid = 1'b0; tick();
        chk("addr_drained", 32'(out_valid), 32'h0);

        // Lane b stalled: fills after two words, third is held off
        out_ready = 4'b1101;
        send(8'h51, 2'd1);
        chk("bp_ready_1", 32'(in_ready), 32'd1);
        tick();
        send(8'h52, 2'd1); tick();
        send(8'h53, 2'd1);
        chk("bp_lane_full", 32'(lane_full), 32'b0010);
        chk("bp_ready_3", 32'(in_ready), 32'd0);
        chk("bp_head_b", 32'(lane_word(1)), 32'h51);
        in_sel = 2'd2;
        #1;
        chk("bp_other_lane_ready", 32'(in_ready), 32'd1);
        in_sel = 2'd1;
        out_ready = 4'b1111;
        #1;
        chk("bp_no_bypass", 32'(in_ready), 32'd0);
        tick();
        out_ready = 4'b1101;
        chk("bp_after_pop_cnt", 32'(acc_cnt), 32'd6);
        chk("bp_after_pop_ready", 32'(in_ready), 32'd1);
        chk("bp_after_pop_head", 32'(lane_word(1)), 32'h52);
        tick();
        in_valid = 1'b0;
        chk("bp_third_cnt", 32'(acc_cnt), 32'd7);
        chk("bp_third_full", 32'(lane_full), 32'b0010);
        out_ready = 4'b1111;
        tick();
        chk("bp_drain_head", 32'(lane_word(1)), 32'h53);
        tick();
        chk("bp_drained", 32'(out_valid), 32'h0);

        // Round-robin across a wrap, then a stall; pointer resumes at c
        rr_mode = 1'b1;
        in_sel  = 2'd3;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) begin
                in_valid = 1'b0;
                tick();
                chk("rr_stall_empty", 32'(out_valid), 32'h0);
                tick();
            end
            send(rr_words[k], 2'd3);
            tick();
            chk($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'(4'b0001 << rr_lanes[k]));
            chk($sformatf("rr_data_%0d", k), 32'(lane_word(rr_lanes[k])), 32'(rr_words[k]));
        end
        chk("rr_acc_cnt", 32'(acc_cnt), 32'd14);
        in_valid = 1'b0;
        tick();

        // Simultaneous push and pop on lane a keeps count at one
        rr_mode = 1'b0;
        out_ready = 4'b0000;
        send(8'hB1, 2'd0); tick();
        chk("pp_setup_valid", 32'(out_valid), 32'b0001);
        send(8'hB2, 2'd0); out_ready = 4'b0001; tick();
        chk("pp_valid", 32'(out_valid), 32'b0001);
        chk("pp_head", 32'(lane_word(0)), 32'hB2);
        chk("pp_not_full", 32'(lane_full), 32'h0);
        in_valid = 1'b0; out_ready = 4'b0000; tick();
        chk("pp_hold_valid", 32'(out_valid), 32'b0001);
        chk("pp_acc_cnt", 32'(acc_cnt), 32'd16);

        // Reset with data buffered in several lanes
        send(8'hC1, 2'd1); tick();
        send(8'hC2, 2'd2); tick();
        chk("mr_pre_valid", 32'(out_valid), 32'b0111);
        chk("mr_pre_cnt", 32'(acc_cnt), 32'd18);
        rst = 1'b1; out_ready = 4'b1111; send(8'hC3, 2'd3);
        #1;
        chk("mr_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("mr_out_valid", 32'(out_valid), 32'h0);
        chk("mr_acc_cnt", 32'(acc_cnt), 32'd0);
        rst = 1'b0; rr_mode = 1'b1; send(8'hD0, 2'd3);
        #1;
        chk("mr_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("mr_rr_lane_a", 32'(out_valid), 32'b0001);
        chk("mr_rr_data", 32'(lane_word(0)), 32'hD0);
        chk("mr_rr_cnt", 32'(acc_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux4_dispatch.md
# demux4_dispatch

Clocked, flow-controlled 1-to-4 dispatcher that feeds the combinational 1:4 demux stage. It accepts one word per cycle on a valid/ready input and routes it to one of four output lanes, either by an explicit 2-bit select or round-robin. Each lane has a small FIFO so that a stalled consumer blocks only its own lane. It also keeps an accepted-word counter for bring-up visibility.

## Interface
Parameters:
- WIDTH, 8, data word width in bits
- DEPTH, 2, entries per lane FIFO; power of two, >= 2

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_data  input  WIDTH  word to dispatch
- in_sel  input  2  destination lane (0=a,1=b,2=c,3=d) when rr_mode=0
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  dispatcher can accept this cycle
- rr_mode  input  1  1 = round-robin lane choice; in_sel ignored
- out_data  output  4*WIDTH  lane i head word at bits [i*WIDTH +: WIDTH]
- out_valid  output  4  lane i FIFO non-empty
- out_ready  input  4  lane i consumer takes head this cycle
- lane_full  output  4  lane i FIFO holds DEPTH words
- acc_cnt  output  16  count of accepted input words

## Operation
- Target lane T = rr_ptr if rr_mode=1, else in_sel.
- in_ready = !lane_full[T] && !rst. No same-cycle bypass: a full lane stays not-ready even if it is popped in the same cycle.
- Accept happens when in_valid && in_ready. On accept:
  - in_data is written at lane T's write pointer.
  - acc_cnt increments and wraps 0xFFFF -> 0.
  - If rr_mode=1, rr_ptr advances T -> T+1 mod 4 (3 wraps to 0).
- rr_ptr holds when there is no accept, and holds across rr_mode changes. It is never re-seeded except by reset.
- Pop on lane i happens when out_valid[i] && out_ready[i]; the read pointer advances. out_ready while the lane is empty has no effect.
- Per-lane count: push only -> +1; pop only -> -1; push and pop together -> unchanged, with both pointers advancing. Pointers wrap modulo DEPTH.
- Each FIFO is first-word fall-through: out_data lane i always shows the head entry. Its value is don't-care while out_valid[i]=0.
- Lanes are fully independent. Back-pressure on one lane never blocks writes to another lane.

## Timing
- Reset (rst high at a clock edge) clears all counts, pointers, rr_ptr and acc_cnt to 0. out_valid=0, lane_full=0, and in_ready=0 while rst is high.
- In the first cycle after rst is released, in_ready=1.
- Latency: a word accepted at edge N shows out_valid[T]=1 and its data on out_data from just after edge N (cycle N+1). Minimum input-to-output latency is 1 cycle.
- Throughput: 1 word/cycle while the target lane is not full.
- A lane that is popped every cycle sustains 1 word/cycle with count stable.
- in_ready depends combinationally on rr_mode, in_sel and the registered lane state. It does not depend on in_valid.
- Reset mid-operation discards all buffered words on the next edge. No pops or accepts happen on that edge.

## Structure
- Package demux4_pkg:
  - LANES=4 and SEL_W=2.
  - typedef lane_idx_t (2-bit) for lane indices.
  - Lane index constants LANE_A..LANE_D.
- Sub-module lane_fifo: parameters WIDTH and DEPTH. Ports clk, rst, push, push_data, pop, head_data, not_empty, full. Four instances, generated over LANES.
- Top level holds target selection, rr_ptr, acc_cnt and the push/pop decode.

## Test plan
- Reset release: rst=1 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0000, acc_cnt=0. The cycle after release -> in_ready=1.
- Addressed routing:
  - Stimulus: rr_mode=0, out_ready=1111. Send 0x11,0x22,0x33,0x44 with in_sel=0,1,2,3 on consecutive cycles.
  - Response: each word appears on lanes a,b,c,d one cycle after its accept; acc_cnt=4.
- Lane full / back-pressure:
  - Stimulus: DEPTH=2, out_ready[1]=0, rr_mode=0, send 3 words with in_sel=1.
  - Response: first two accepted, lane_full[1]=1, in_ready=0 for the third.
  - Follow-up: with in_sel=2 in that same state, in_ready=1.
  - Follow-up: one pop on lane b -> third word accepted the following cycle.
- Round-robin wrap:
  - Stimulus: rr_mode=1, all lanes ready, 6 words 0xA0..0xA5.
  - Response: lanes a,b,c,d,a,b receive them in order.
  - Follow-up: stall in_valid for 2 cycles, then one word -> goes to lane c.
- Simultaneous push/pop:
  - Stimulus: lane a holds 1 word; push to lane a and pop lane a in the same cycle.
  - Response: count stays 1, head becomes the new word, out_valid[0] stays 1.
- Mid-operation reset: with lanes holding data, assert rst for 1 cycle -> out_valid=0000, acc_cnt=0, rr_ptr=0 (next RR word goes to lane a).
